// File: rtl/lsu_pipeline_if.sv
// Bundle of the EX/MEM entry, memory bus and MEM/WB result signals of lsu_pipeline.
// master is the LSU side; slave is the surrounding pipeline / bus fabric side.
interface lsu_pipeline_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic [31:0] in_rs2_data;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        in_reg_wen;
  logic        in_mem_ren;
  logic        in_mem_wen;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_reg_wen;
  logic [31:0] out_wdata;
  logic        out_is_load;
  logic        out_bus_err;
  logic        busy;

  modport master (
    input  in_valid, in_pc, in_alu_result, in_rs2_data, in_rd, in_funct3,
           in_reg_wen, in_mem_ren, in_mem_wen,
    output in_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output out_valid, out_pc, out_rd, out_reg_wen, out_wdata, out_is_load, out_bus_err,
    input  out_ready,
    output busy
  );

  modport slave (
    output in_valid, in_pc, in_alu_result, in_rs2_data, in_rd, in_funct3,
           in_reg_wen, in_mem_ren, in_mem_wen,
    input  in_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  out_valid, out_pc, out_rd, out_reg_wen, out_wdata, out_is_load, out_bus_err,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/lsu_pipeline.sv
// MEM stage: single-outstanding load/store over a valid/ready bus, registered MEM/WB result.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses without a bus transaction.
module lsu_pipeline #(
  parameter int unsigned TIMEOUT = 256
) (
  input logic            clk,
  input logic            rst_n,
  lsu_pipeline_if.master bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [31:0]   addr_q, sdata_q, pc_q, rdata_q;
  logic [4:0]    rd_q;
  logic [2:0]    f3_q;
  logic          reg_wen_q, ren_q, wen_q, err_q;
  logic [CW-1:0] tmo_cnt;

  logic          accept, is_mem, misaligned, timeout_hit;
  logic          req_valid, req_fire, rsp_take;
  logic [3:0]    strb;
  logic [31:0]   wdata_lane, load_val, done_wdata;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_mem       = bus.in_mem_ren || bus.in_mem_wen;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = is_mem &&
                      ((bus.in_funct3[1:0] == 2'b01 && bus.in_alu_result[0]) ||
                       (bus.in_funct3[1:0] == 2'b10 && bus.in_alu_result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (state == REQ || state == WAIT) &&
                       (tmo_cnt == CW'(TIMEOUT - 1));
  assign req_fire    = req_valid && bus.mem_req_ready;
  assign rsp_take    = bus.mem_rsp_valid && ((state == WAIT) || req_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The request is withdrawn in the cycle the timeout fires so no handshake races the abort.
  always_comb begin
    state_nx  = state;
    req_valid = 1'b0;
    case (state)
      IDLE: if (accept && is_mem) state_nx = misaligned ? DONE : REQ;
      REQ: begin
        req_valid = !timeout_hit;
        if (timeout_hit)            state_nx = DONE;
        else if (bus.mem_req_ready) state_nx = bus.mem_rsp_valid ? DONE : WAIT;
      end
      WAIT:    if (bus.mem_rsp_valid || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy          = (state != IDLE);
  assign bus.mem_req_valid = req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            tmo_cnt <= '0;
    else if (state == REQ || state == WAIT) tmo_cnt <= tmo_cnt + CW'(1);
    else                                    tmo_cnt <= '0;
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        strb       = 4'b0001 << addr_q[1:0];
        wdata_lane = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        strb       = 4'b0011 << addr_q[1:0];
        wdata_lane = {2{sdata_q[15:0]}};
      end
      default: begin
        strb       = 4'b1111;
        wdata_lane = sdata_q;
      end
    endcase
  end

  assign bus.mem_req_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_wstrb = wen_q ? strb : 4'b0000;
  assign bus.mem_req_wdata = wen_q ? wdata_lane : 32'h0;

  assign byte_v = rdata_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = rdata_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = rdata_q;
    endcase
  end

  assign done_wdata = (err_q || wen_q || !ren_q) ? 32'h0 : load_val;

  // Entry fields are captured only at accept, so later EX/MEM changes cannot disturb the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      sdata_q   <= '0;
      pc_q      <= '0;
      rdata_q   <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      reg_wen_q <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept && is_mem) begin
      addr_q    <= bus.in_alu_result;
      sdata_q   <= bus.in_rs2_data;
      pc_q      <= bus.in_pc;
      rd_q      <= bus.in_rd;
      f3_q      <= bus.in_funct3;
      reg_wen_q <= bus.in_reg_wen;
      ren_q     <= bus.in_mem_ren;
      wen_q     <= bus.in_mem_wen;
      err_q     <= misaligned;
    end else if (rsp_take) begin
      rdata_q   <= bus.mem_rsp_rdata;
      err_q     <= bus.mem_rsp_err;
    end else if (timeout_hit) begin
      err_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_pc      <= '0;
      bus.out_rd      <= '0;
      bus.out_reg_wen <= 1'b0;
      bus.out_wdata   <= '0;
      bus.out_is_load <= 1'b0;
      bus.out_bus_err <= 1'b0;
    end else if (accept && !is_mem) begin
      bus.out_valid   <= 1'b1;
      bus.out_pc      <= bus.in_pc;
      bus.out_rd      <= bus.in_rd;
      bus.out_reg_wen <= bus.in_reg_wen;
      bus.out_wdata   <= bus.in_alu_result;
      bus.out_is_load <= 1'b0;
      bus.out_bus_err <= 1'b0;
    end else if (state == DONE) begin
      bus.out_valid   <= 1'b1;
      bus.out_pc      <= pc_q;
      bus.out_rd      <= rd_q;
      bus.out_reg_wen <= reg_wen_q && ren_q && !wen_q && !err_q;
      bus.out_wdata   <= done_wdata;
      bus.out_is_load <= ren_q;
      bus.out_bus_err <= err_q;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid   <= 1'b0;
      bus.out_pc      <= '0;
      bus.out_rd      <= '0;
      bus.out_reg_wen <= 1'b0;
      bus.out_wdata   <= '0;
      bus.out_is_load <= 1'b0;
      bus.out_bus_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu_pipeline.sv
// Testbench for lsu_pipeline: vector table with request/result scoreboards, plus
// hand sequences for backpressure, timeout, misalignment and mid-transaction reset.
module tb_lsu_pipeline;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lsu_pipeline_if bi ();
  lsu_pipeline_if bt ();

  lsu_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bi.master));
  lsu_pipeline #(.TIMEOUT(4)) dut_to (.clk(clk), .rst_n(rst_n), .bus(bt.master));

  typedef struct {
    logic [31:0] pc, alu, rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        reg_wen, ren, wen;
    int          stall, dly;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_bwdata, e_wdata;
    logic        e_reg_wen, e_is_load, e_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        reg_wen, is_load, err;
  } out_exp_t;

  int          tests = 0;
  int          fails = 0;
  req_exp_t    req_q[$];
  out_exp_t    out_q[$];
  logic [31:0] mem [logic [29:0]];
  int          cur_stall = 0;
  int          cur_dly = 0;
  logic        cur_err = 1'b0;
  vec_t        vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic serviceRequest(output logic [31:0] rdata);
    req_exp_t    e;
    logic [29:0] k;
    logic [31:0] w;
    k = bi.mem_req_addr[31:2];
    tests++;
    if (req_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_req: got request addr 0x%08h, expected no request", bi.mem_req_addr);
    end else begin
      tests--;
      e = req_q.pop_front();
      checkOutput("req_addr", bi.mem_req_addr, e.addr);
      checkOutput("req_wen", bi.mem_req_wen, e.wen);
      checkOutput("req_wstrb", bi.mem_req_wstrb, e.wstrb);
      if (e.wen) checkOutput("req_wdata", bi.mem_req_wdata, e.wdata);
    end
    w = mem.exists(k) ? mem[k] : 32'h0;
    if (bi.mem_req_wen) begin
      for (int i = 0; i < 4; i++)
        if (bi.mem_req_wstrb[i]) w[8*i +: 8] = bi.mem_req_wdata[8*i +: 8];
      mem[k] = w;
    end
    rdata = w;
  endtask

  // Bus responder: stalls ready, then answers after a configurable delay (0 = same cycle).
  initial begin
    int          stall_cnt;
    int          pend_cnt;
    bit          pend;
    logic [31:0] pend_data;
    logic [31:0] rd;
    stall_cnt = 0;
    pend_cnt  = 0;
    pend      = 1'b0;
    pend_data = '0;
    bi.mem_req_ready = 1'b0;
    bi.mem_rsp_valid = 1'b0;
    bi.mem_rsp_rdata = '0;
    bi.mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      bi.mem_req_ready = 1'b0;
      bi.mem_rsp_valid = 1'b0;
      bi.mem_rsp_err   = 1'b0;
      if (!rst_n) begin
        stall_cnt = 0;
        pend      = 1'b0;
      end else if (pend) begin
        if (pend_cnt == 0) begin
          bi.mem_rsp_valid = 1'b1;
          bi.mem_rsp_rdata = pend_data;
          bi.mem_rsp_err   = cur_err;
          pend             = 1'b0;
        end else pend_cnt--;
      end else if (bi.mem_req_valid) begin
        if (stall_cnt < cur_stall) stall_cnt++;
        else begin
          stall_cnt        = 0;
          bi.mem_req_ready = 1'b1;
          serviceRequest(rd);
          if (cur_dly == 0) begin
            bi.mem_rsp_valid = 1'b1;
            bi.mem_rsp_rdata = rd;
            bi.mem_rsp_err   = cur_err;
          end else begin
            pend      = 1'b1;
            pend_cnt  = cur_dly - 1;
            pend_data = rd;
          end
        end
      end
    end
  end

  // Result monitor: compares every consumed MEM/WB entry against the scoreboard.
  initial begin
    out_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bi.out_valid && bi.out_ready) begin
        if (out_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_out: got entry pc 0x%08h, expected none", bi.out_pc);
        end else begin
          e = out_q.pop_front();
          checkOutput("out_pc", bi.out_pc, e.pc);
          checkOutput("out_rd", bi.out_rd, e.rd);
          checkOutput("out_wdata", bi.out_wdata, e.wdata);
          checkOutput("out_reg_wen", bi.out_reg_wen, e.reg_wen);
          checkOutput("out_is_load", bi.out_is_load, e.is_load);
          checkOutput("out_bus_err", bi.out_bus_err, e.err);
        end
      end
    end
  end

  task automatic driveEntry(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [4:0] rd, input logic [2:0] f3,
                            input logic reg_wen, input logic ren, input logic wen);
    bi.in_pc         = pc;
    bi.in_alu_result = alu;
    bi.in_rs2_data   = rs2;
    bi.in_rd         = rd;
    bi.in_funct3     = f3;
    bi.in_reg_wen    = reg_wen;
    bi.in_mem_ren    = ren;
    bi.in_mem_wen    = wen;
    bi.in_valid      = 1'b1;
  endtask

  task automatic pushOut(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wdata,
                         input logic reg_wen, input logic is_load, input logic err);
    out_q.push_back('{pc, rd, wdata, reg_wen, is_load, err});
  endtask

  task automatic waitInReady(input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bi.in_ready && c < 100);
    checkOutput(name, bi.in_ready, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.ren || v.wen) req_q.push_back('{v.e_addr, v.wen, v.e_strb, v.e_bwdata});
    pushOut(v.pc, v.rd, v.e_wdata, v.e_reg_wen, v.e_is_load, v.e_err);
    waitInReady("in_ready_wait");
    cur_stall = v.stall;
    cur_dly   = v.dly;
    cur_err   = v.err;
    driveEntry(v.pc, v.alu, v.rs2, v.rd, v.f3, v.reg_wen, v.ren, v.wen);
    @(negedge clk);
    bi.in_valid      = 1'b0;
    bi.in_funct3     = ~v.f3;
    bi.in_alu_result = ~v.alu;
    bi.in_rs2_data   = ~v.rs2;
  endtask

  task automatic drainOut();
    int c;
    c = 0;
    while (out_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput("drain_out_q", out_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    // pc, alu, rs2, rd, f3, reg_wen, ren, wen, stall, dly, err, addr, strb, bus wdata, out wdata, reg_wen, is_load, err
    vecs[0]  = '{32'h100, 32'h00001234, 32'h0,        5'd5,  3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h00001234, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h104, 32'h80000003, 32'h0,        5'd6,  3'b000, 1'b1, 1'b1, 1'b0, 2, 1, 1'b0, 32'h80000000, 4'h0, 32'h0,        32'hFFFFFF80, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{32'h108, 32'h80000102, 32'hDEADBEEF, 5'd0,  3'b001, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 32'h80000100, 4'hC, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h10C, 32'h80000102, 32'h0,        5'd7,  3'b101, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0, 32'h80000100, 4'h0, 32'h0,        32'h0000BEEF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{32'h110, 32'h80000102, 32'h0,        5'd8,  3'b001, 1'b1, 1'b1, 1'b0, 0, 2, 1'b0, 32'h80000100, 4'h0, 32'h0,        32'hFFFFBEEF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'h114, 32'h80000004, 32'h0,        5'd9,  3'b010, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 32'h80000004, 4'h0, 32'h0,        32'h12345678, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{32'h118, 32'h80000005, 32'h0,        5'd10, 3'b100, 1'b1, 1'b1, 1'b0, 1, 1, 1'b0, 32'h80000004, 4'h0, 32'h0,        32'h00000056, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'h11C, 32'h80000006, 32'h0,        5'd11, 3'b000, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 32'h80000004, 4'h0, 32'h0,        32'h00000034, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{32'h120, 32'h80000201, 32'h000000A5, 5'd0,  3'b000, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 32'h80000200, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h124, 32'h80000200, 32'h0,        5'd12, 3'b010, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 32'h80000200, 4'h0, 32'h0,        32'h0000A500, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{32'h128, 32'h80000300, 32'hCAFEF00D, 5'd0,  3'b010, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 32'h80000300, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h12C, 32'h80000004, 32'h0,        5'd13, 3'b001, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 32'h80000004, 4'h0, 32'h0,        32'h00005678, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{32'h130, 32'hFFFFFFFF, 32'h0,        5'd14, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0,        4'h0, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h134, 32'h80000004, 32'h0,        5'd15, 3'b000, 1'b1, 1'b1, 1'b0, 0, 1, 1'b1, 32'h80000004, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1};
    vecs[14] = '{32'h138, 32'h80000300, 32'h0,        5'd16, 3'b010, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 32'h80000300, 4'h0, 32'h0,        32'hCAFEF00D, 1'b1, 1'b1, 1'b0};

    mem[30'h20000000] = 32'h80FFFFFF;
    mem[30'h20000001] = 32'h12345678;

    bi.in_valid = 1'b0; bi.in_pc = '0; bi.in_alu_result = '0; bi.in_rs2_data = '0;
    bi.in_rd = '0; bi.in_funct3 = '0; bi.in_reg_wen = 1'b0; bi.in_mem_ren = 1'b0;
    bi.in_mem_wen = 1'b0; bi.out_ready = 1'b1;
    bt.in_valid = 1'b0; bt.in_pc = '0; bt.in_alu_result = '0; bt.in_rs2_data = '0;
    bt.in_rd = '0; bt.in_funct3 = '0; bt.in_reg_wen = 1'b0; bt.in_mem_ren = 1'b0;
    bt.in_mem_wen = 1'b0; bt.out_ready = 1'b1; bt.mem_req_ready = 1'b0;
    bt.mem_rsp_valid = 1'b0; bt.mem_rsp_rdata = '0; bt.mem_rsp_err = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", bi.out_valid, 0);
    checkOutput("rst_out_wdata", bi.out_wdata, 0);
    checkOutput("rst_out_reg_wen", bi.out_reg_wen, 0);
    checkOutput("rst_out_bus_err", bi.out_bus_err, 0);
    checkOutput("rst_mem_req_valid", bi.mem_req_valid, 0);
    checkOutput("rst_busy", bi.busy, 0);
    checkOutput("rst_in_ready", bi.in_ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);
    drainOut();
    checkOutput("req_q_empty", req_q.size(), 0);

    // Backpressure: result held while out_ready is low, next entry taken on the release cycle.
    @(negedge clk);
    bi.out_ready = 1'b0;
    pushOut(32'h140, 5'd1, 32'h00000011, 1'b1, 1'b0, 1'b0);
    driveEntry(32'h140, 32'h00000011, 32'h0, 5'd1, 3'b000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    pushOut(32'h144, 5'd2, 32'h00000022, 1'b1, 1'b0, 1'b0);
    driveEntry(32'h144, 32'h00000022, 32'h0, 5'd2, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_in_ready_low", bi.in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_wdata", bi.out_wdata, 32'h00000011);
      checkOutput("bp_hold_valid", bi.out_valid, 1);
      checkOutput("bp_in_ready_held", bi.in_ready, 0);
    end
    @(negedge clk);
    bi.out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_release", bi.in_ready, 1);
    @(negedge clk);
    bi.in_valid = 1'b0;
    checkOutput("bp_next_wdata", bi.out_wdata, 32'h00000022);
    checkOutput("bp_next_valid", bi.out_valid, 1);
    drainOut();

`ifdef LSU_MISALIGN_CHECK_EN
    pushOut(32'h150, 5'd4, 32'h0, 1'b0, 1'b1, 1'b1);
    waitInReady("mis_in_ready");
    driveEntry(32'h150, 32'h80000001, 32'h0, 5'd4, 3'b010, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bi.in_valid = 1'b0;
    checkOutput("mis_no_req", bi.mem_req_valid, 0);
    checkOutput("mis_busy", bi.busy, 1);
    checkOutput("mis_not_yet_valid", bi.out_valid, 0);
    @(negedge clk);
    checkOutput("mis_out_valid", bi.out_valid, 1);
    checkOutput("mis_bus_err", bi.out_bus_err, 1);
    checkOutput("mis_no_req_after", bi.mem_req_valid, 0);
    drainOut();
`endif

    // Timeout on the TIMEOUT=4 instance: bus never answers, late pulse must be ignored.
    @(negedge clk);
    bt.in_pc = 32'h200; bt.in_alu_result = 32'h80000000; bt.in_funct3 = 3'b010;
    bt.in_rd = 5'd3; bt.in_reg_wen = 1'b1; bt.in_mem_ren = 1'b1; bt.in_valid = 1'b1;
    @(negedge clk);
    bt.in_valid = 1'b0;
    checkOutput("to_req_valid", bt.mem_req_valid, 1);
    repeat (3) @(negedge clk);
    checkOutput("to_req_dropped", bt.mem_req_valid, 0);
    checkOutput("to_busy", bt.busy, 1);
    c = 0;
    while (!bt.out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput("to_latency", c, 2);
    checkOutput("to_out_valid", bt.out_valid, 1);
    checkOutput("to_bus_err", bt.out_bus_err, 1);
    checkOutput("to_reg_wen", bt.out_reg_wen, 0);
    checkOutput("to_wdata", bt.out_wdata, 0);
    checkOutput("to_is_load", bt.out_is_load, 1);
    checkOutput("to_idle", bt.busy, 0);
    @(negedge clk);
    bt.mem_rsp_valid = 1'b1;
    bt.mem_rsp_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bt.mem_rsp_valid = 1'b0;
    checkOutput("to_late_out_valid", bt.out_valid, 0);
    checkOutput("to_late_busy", bt.busy, 0);
    checkOutput("to_late_req", bt.mem_req_valid, 0);
    @(negedge clk);
    checkOutput("to_late_out_valid2", bt.out_valid, 0);

    // Reset while a request is stalled: FSM and bus request must drop at once.
    waitInReady("rmid_in_ready");
    cur_stall = 20;
    cur_dly   = 0;
    cur_err   = 1'b0;
    driveEntry(32'h160, 32'h80000000, 32'h0, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bi.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rmid_busy_before", bi.busy, 1);
    checkOutput("rmid_req_before", bi.mem_req_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_busy", bi.busy, 0);
    checkOutput("rmid_req", bi.mem_req_valid, 0);
    checkOutput("rmid_out_valid", bi.out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur_stall = 0;
    pushOut(32'h164, 5'd6, 32'h00000ABC, 1'b1, 1'b0, 1'b0);
    waitInReady("rmid_recover_ready");
    driveEntry(32'h164, 32'h00000ABC, 32'h0, 5'd6, 3'b000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bi.in_valid = 1'b0;
    drainOut();
    checkOutput("final_req_q_empty", req_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
